pipelined_adder: RTL and testbench
==================================

# pipelined_adder

Parametrised, pipelined two-operand adder/subtractor with carry-in, carry-out and signed-overflow flags. It generalises the team's 8-bit combinational parallel adder in three ways:
- Arbitrary width.
- A carry chain split into registered chunks for timing closure.
- A subtract mode and a valid/ready handshake with full back-pressure.

It sits between operand-producing logic and any consumer that needs one result per cycle at high clock rates.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages; each stage resolves one chunk of CW = WIDTH/STAGES bits; legal range 1..WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  pipeline accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (subtract).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out (add) or NOT-borrow (subtract).
- ovf  output  1  two's-complement signed overflow.

## Operation
- Add mode: {cout, sum} = a + b + cin, computed modulo 2^WIDTH with the carry captured in cout.
- Subtract mode: {cout, sum} = a + ~b + ~cin, i.e. a − b − cin.
  - cout = 1 means no borrow occurred.
  - Example: a=5, b=3, cin=0 gives sum=2, cout=1.
- Overflow: ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]), where b_eff is b in add mode and ~b in subtract mode.
- Inversion of b and cin happens before stage 0. Internally, stage logic only ever adds.
- Stage k (k = 0..STAGES−1):
  - Adds chunk k of a and b_eff plus the carry registered by stage k−1 (stage 0 uses the effective carry-in).
  - Registers its CW-bit partial sum and its carry.
  - Forwards the not-yet-consumed upper chunks of a and b_eff, and the already-resolved lower partial sums, in skew registers.
- Each stage has a valid bit, so the pipeline accepts one beat per cycle and holds up to STAGES beats in flight.
- Back-pressure is a global stall: in_ready = !(out_valid && !out_ready).
  - When a stall is in effect, every stage register and valid bit holds its value.
  - A beat is accepted when in_valid && in_ready.
  - A result is delivered when out_valid && out_ready.
- Reset:
  - out_valid=0, sum=0, cout=0, ovf=0, and all internal valid bits are 0.
  - in_ready is 1 starting in the first cycle after reset is released.
  - A reset asserted mid-operation discards every in-flight beat; no partial result is ever presented.
- Outputs are held stable while out_valid && !out_ready.

## Timing
- Latency: exactly STAGES cycles from the accepting edge to out_valid, when no stall occurs. Each stall cycle adds one cycle of latency.
- Throughput: 1 result per cycle while out_ready stays high.
- STAGES=1: a single registered adder with latency 1.
- Simultaneous accept and deliver in the same cycle is legal and loses no beat.
- Inputs a, b, cin and sub are sampled only on the accepting edge.
- Wrap-around: a sum ≥ 2^WIDTH wraps, with the excess reflected in cout; no saturation is applied.
- The critical path is one CW-bit carry chain plus the stall mux.

## Structure
- Package adder_pkg:
  - function chunk_width(WIDTH, STAGES).
  - localparam mode encodings ADD=1'b0 and SUB=1'b1.
  - Elaboration-time check that WIDTH % STAGES == 0.
- Sub-module adder_stage:
  - Parameter CW.
  - Combinational CW-bit add with carry-in/carry-out, plus the stage's result/carry/valid registers with enable and synchronous reset.
- The top level instantiates adder_stage in a generate loop and owns the skew registers and handshake logic.

## Test plan
- WIDTH=8, STAGES=2: a=0x1B, b=0x25, cin=0, add → after 2 cycles sum=0x40, cout=0, ovf=0.
- WIDTH=8, STAGES=2:
  - a=0xFF, b=0x01, cin=1, add → sum=0x01, cout=1, ovf=0.
  - a=0x7F, b=0x01, cin=0, add → sum=0x80, ovf=1.
- WIDTH=8, STAGES=4, subtract: a=0x05, b=0x03, cin=0 → sum=0x02, cout=1; a=0x03, b=0x05 → sum=0xFE, cout=0, ovf=0.
- WIDTH=32, STAGES=4, back-to-back operands 0..15 paired with b=0xFFFFFFFF:
  - Hold out_ready=0 for 3 cycles mid-stream.
  - Required: in_ready drops, no loss or duplication, results in order, each equal to a−1 mod 2^32 with cout=(a≠0).
- Reset mid-stream with 3 beats in flight → out_valid=0 on the next cycle, and no stale results appear afterward.
- STAGES=1, WIDTH=8: a=0xFF, b=0xFF, cin=1, add → 1 cycle later sum=0xFF, cout=1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder: mode encodings and
// parameter helpers used at elaboration time.
package adder_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Each stage must own a whole, equal-sized chunk of the carry chain.
  function automatic bit width_legal(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_stage.sv
// One pipeline stage: a CW-bit add with carry-in/carry-out, followed by
// the stage's partial-sum, carry and valid registers.
module adder_stage #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          valid_in,
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout,
  output logic          valid
);

  logic [CW:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};

  always_ff @(posedge clk) begin
    if (rst) begin
      sum   <= '0;
      cout  <= 1'b0;
      valid <= 1'b0;
    end else if (en) begin
      sum   <= total[CW-1:0];
      cout  <= total[CW];
      valid <= valid_in;
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract with carry and signed-overflow flags. The carry
// chain is cut into STAGES registered chunks; a global stall gives back-pressure.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW   = chunk_width(WIDTH, STAGES);
  localparam int LAST = STAGES - 1;

  if (!width_legal(WIDTH, STAGES)) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             a_msb;
  logic             b_msb;

  logic [CW-1:0]    opa     [STAGES];
  logic [CW-1:0]    opb     [STAGES];
  logic             cin_s   [STAGES];
  logic             vin_s   [STAGES];
  logic [CW-1:0]    sum_s   [STAGES];
  logic             cout_s  [STAGES];
  logic             valid_s [STAGES];
  // Skew registers travelling with each beat: unconsumed operand chunks
  // shifted down to bit 0, and resolved lower sums shifted in from the top.
  logic [WIDTH-1:0] a_sk    [STAGES];
  logic [WIDTH-1:0] b_sk    [STAGES];
  logic [WIDTH-1:0] lo_sk   [STAGES];

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;
  assign b_eff    = (sub == SUB) ? ~b : b;
  assign cin_eff  = (sub == SUB) ? ~cin : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign opa[0]   = a[CW-1:0];
      assign opb[0]   = b_eff[CW-1:0];
      assign cin_s[0] = cin_eff;
      assign vin_s[0] = in_valid;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_sk[0]  <= '0;
          b_sk[0]  <= '0;
          lo_sk[0] <= '0;
        end else if (en) begin
          a_sk[0]  <= a >> CW;
          b_sk[0]  <= b_eff >> CW;
          lo_sk[0] <= '0;
        end
      end
    end else begin : g_next
      assign opa[k]   = a_sk[k-1][CW-1:0];
      assign opb[k]   = b_sk[k-1][CW-1:0];
      assign cin_s[k] = cout_s[k-1];
      assign vin_s[k] = valid_s[k-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          a_sk[k]  <= '0;
          b_sk[k]  <= '0;
          lo_sk[k] <= '0;
        end else if (en) begin
          a_sk[k]  <= a_sk[k-1] >> CW;
          b_sk[k]  <= b_sk[k-1] >> CW;
          lo_sk[k] <= {sum_s[k-1], lo_sk[k-1][WIDTH-1:CW]};
        end
      end
    end

    adder_stage #(.CW(CW)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .valid_in (vin_s[k]),
      .a        (opa[k]),
      .b        (opb[k]),
      .cin      (cin_s[k]),
      .sum      (sum_s[k]),
      .cout     (cout_s[k]),
      .valid    (valid_s[k])
    );
  end

  // Operand sign bits are captured alongside the top chunk for the overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
    end else if (en) begin
      a_msb <= opa[LAST][CW-1];
      b_msb <= opb[LAST][CW-1];
    end
  end

  if (STAGES > 1) begin : g_sum_multi
    assign sum = {sum_s[LAST], lo_sk[LAST][WIDTH-1:CW]};
  end else begin : g_sum_single
    assign sum = sum_s[0];
  end

  assign cout      = cout_s[LAST];
  assign out_valid = valid_s[LAST];
  assign ovf       = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: four configurations, table vectors plus
// scoreboarded stream, stall and mid-stream reset sequences.
module tb_pipelined_adder;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_x = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // shared 8-bit stimulus
  logic [7:0] a8 = '0, b8 = '0;
  logic cin8 = 1'b0, sub8 = 1'b0;
  logic v81 = 1'b0, v82 = 1'b0, v84 = 1'b0;
  logic ordy8 = 1'b1;
  logic ir81, ir82, ir84, ov81, ov82, ov84;
  logic [7:0] s81, s82, s84;
  logic co81, co82, co84, of81, of82, of84;

  logic [31:0] a32 = '0, b32 = 32'hFFFF_FFFF;
  logic cin32 = 1'b0, sub32 = 1'b0, v32 = 1'b0, or32 = 1'b1;
  logic ir32, ov32, co32, of32;
  logic [31:0] s32;

  exp_t q81[$], q82[$], q84[$], q32[$];
  logic [31:0] hold_s;
  bit   hold_v = 1'b0;
  int   n32 = 0;

  pipelined_adder #(.WIDTH(8), .STAGES(1)) d81 (
    .clk(clk), .rst(rst), .in_valid(v81), .in_ready(ir81), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov81), .out_ready(ordy8),
    .sum(s81), .cout(co81), .ovf(of81));

  pipelined_adder #(.WIDTH(8), .STAGES(2)) d82 (
    .clk(clk), .rst(rst), .in_valid(v82), .in_ready(ir82), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov82), .out_ready(ordy8),
    .sum(s82), .cout(co82), .ovf(of82));

  pipelined_adder #(.WIDTH(8), .STAGES(4)) d84 (
    .clk(clk), .rst(rst | rst_x), .in_valid(v84), .in_ready(ir84), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov84), .out_ready(ordy8),
    .sum(s84), .cout(co84), .ovf(of84));

  pipelined_adder #(.WIDTH(32), .STAGES(4)) d32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(ir32), .a(a32), .b(b32),
    .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(or32),
    .sum(s32), .cout(co32), .ovf(of32));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  task automatic check_out(input string nm, input int stages, input exp_t e,
                           input logic [31:0] s, input logic co, input logic of,
                           input bit lat);
    check({nm, "_sum"}, s, e.sum);
    check({nm, "_cout"}, {31'b0, co}, {31'b0, e.cout});
    check({nm, "_ovf"}, {31'b0, of}, {31'b0, e.ovf});
    if (lat) check({nm, "_latency"}, cyc - e.cyc, stages);
  endtask

  function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b,
                                  input logic ci, input logic sb);
    exp_t e;
    logic [7:0] be;
    logic [8:0] t;
    be = sb ? ~b : b;
    t = {1'b0, a} + {1'b0, be} + {8'b0, (sb ? ~ci : ci)};
    e.sum  = {24'b0, t[7:0]};
    e.cout = t[8];
    e.ovf  = (a[7] == be[7]) && (t[7] != a[7]);
    e.cyc  = 0;
    return e;
  endfunction

  // output monitors (sampled on the falling edge)
  always @(negedge clk) if (!rst && ov81) begin
    if (q81.size() == 0) fail_now("d81_unexpected_output");
    else check_out("d81", 1, q81.pop_front(), {24'b0, s81}, co81, of81, 1'b1);
  end

  always @(negedge clk) if (!rst && ov82) begin
    if (q82.size() == 0) fail_now("d82_unexpected_output");
    else check_out("d82", 2, q82.pop_front(), {24'b0, s82}, co82, of82, 1'b1);
  end

  always @(negedge clk) if (!(rst || rst_x) && ov84) begin
    if (q84.size() == 0) fail_now("d84_unexpected_output");
    else check_out("d84", 4, q84.pop_front(), {24'b0, s84}, co84, of84, 1'b1);
  end

  always @(negedge clk) if (!rst) begin
    if (ov32 && !or32) begin
      if (hold_v) check("d32_hold_sum", s32, hold_s);
      hold_s = s32;
      hold_v = 1'b1;
    end else begin
      hold_v = 1'b0;
    end
    if (ov32 && or32) begin
      if (q32.size() == 0) fail_now("d32_unexpected_output");
      else check_out("d32", 4, q32.pop_front(), s32, co32, of32, 1'b0);
      n32++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[12];
    exp_t e;
    int   i;
    int   it;

    vt[0]  = '{8'h1B, 8'h25, 1'b0, 1'b0, 8'h40, 1'b0, 1'b0};
    vt[1]  = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
    vt[2]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[3]  = '{8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0};
    vt[4]  = '{8'h03, 8'h05, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    vt[5]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    vt[6]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vt[7]  = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vt[8]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[9]  = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
    vt[10] = '{8'h0F, 8'hF1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[11] = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'b0, ov32}, 32'd0);
    check("rst_sum", s32, 32'd0);
    check("rst_cout", {31'b0, co32}, 32'd0);
    check("rst_ovf", {31'b0, of32}, 32'd0);
    check("rst_in_ready", {31'b0, ir32}, 32'd1);

    // table vectors, back-to-back into all three 8-bit configurations
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      a8 = vt[k].a; b8 = vt[k].b; cin8 = vt[k].cin; sub8 = vt[k].sub;
      v81 = 1'b1; v82 = 1'b1; v84 = 1'b1;
      e.sum = {24'b0, vt[k].s}; e.cout = vt[k].co; e.ovf = vt[k].ov; e.cyc = cyc;
      q81.push_back(e); q82.push_back(e); q84.push_back(e);
    end
    // random vectors against the arithmetic model
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
      e = model8(a8, b8, cin8, sub8);
      e.cyc = cyc;
      q81.push_back(e); q82.push_back(e); q84.push_back(e);
    end
    @(posedge clk); #1;
    v81 = 1'b0; v82 = 1'b0; v84 = 1'b0;
    for (int n = 0; n < 50 && (q81.size() + q82.size() + q84.size()) > 0; n++)
      @(posedge clk);
    if ((q81.size() + q82.size() + q84.size()) > 0) fail_now("table_drain_timeout");

    // 32-bit stream of a-1 with a mid-stream stall
    i = 0;
    it = 0;
    while (i < 16 && it < 200) begin
      @(posedge clk); #1;
      or32 = !(it >= 6 && it < 9);
      v32 = 1'b1;
      a32 = i;
      @(negedge clk);
      if (it >= 6 && it < 9) check("d32_in_ready_stall", {31'b0, ir32}, 32'd0);
      if (ir32) begin
        e.sum = 32'(i) - 32'd1; e.cout = (i != 0); e.ovf = 1'b0; e.cyc = 0;
        q32.push_back(e);
        i++;
      end
      it++;
    end
    if (i < 16) fail_now("d32_stream_timeout");
    @(posedge clk); #1;
    v32 = 1'b0;
    or32 = 1'b1;
    for (int n = 0; n < 50 && q32.size() > 0; n++) @(posedge clk);
    @(negedge clk);
    check("d32_delivered_count", n32, 32'd16);
    check("d32_queue_left", q32.size(), 32'd0);

    // reset the 4-stage pipeline with three beats in flight
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      a8 = 8'h11 * k; b8 = 8'h22; cin8 = 1'b0; sub8 = 1'b0; v84 = 1'b1;
    end
    @(posedge clk); #1;
    v84 = 1'b0;
    rst_x = 1'b1;
    @(posedge clk); #1;
    rst_x = 1'b0;
    @(negedge clk);
    check("d84_rst_mid_out_valid", {31'b0, ov84}, 32'd0);
    check("d84_rst_mid_in_ready", {31'b0, ir84}, 32'd1);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      check("d84_no_stale_output", {31'b0, ov84}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
